tetris_board_engine: RTL
========================

Name: tetris_board_engine

Overview:
- Game-state engine that produces the 240-bit playfield word. The VGA pattern generator consumes this word and renders it.
- Holds the locked 20x12 board and one active tetromino. It applies move, rotate and gravity commands with collision checks, then locks the piece, clears full rows and spawns the next piece.
- board_data is the only display interface. Row 0 is the top row; within each row, the MSB is the leftmost column.

Parameters:
SPAWN_X, 4, column of the 4x4 piece-mask origin at spawn (signed, 5 bits)
SPAWN_Y, 0, row of the 4x4 piece-mask origin at spawn (signed, 6 bits)
LFSR_SEED, 16'hACE1, LFSR reset value (used only with PIECE_LFSR_EN)

Ports:
clk  in  1  system clock; all state changes on posedge
rst  in  1  synchronous, active-low reset
btn_left  in  1  single-cycle pulse: move piece left 1 column
btn_right  in  1  single-cycle pulse: move piece right 1 column
btn_rot  in  1  single-cycle pulse: rotate piece clockwise
tick  in  1  single-cycle pulse: gravity/soft-drop, move down 1 row
piece_sel  in  3  next-piece index, sampled in SPAWN (used only without PIECE_LFSR_EN)
board_data  out  240  playfield, registered; cell (r,c) = board_data[239-12r-c]
lines_cleared  out  16  count of cleared rows, wraps at 16'hFFFF -> 0
game_over  out  1  sticky; cleared only by rst
busy  out  1  high in LOCK/CLEAR/SPAWN; commands are ignored while high

Behaviour:
- Reset (rst=0 at posedge):
  - board, board_data and lines_cleared = 0; game_over = 0; busy = 1.
  - State goes to SPAWN; rotation = 0; LFSR = LFSR_SEED.
- Piece set: index 0 I, 1 O, 2 T, 3 S, 4 Z, 5 J, 6 L; index 7 maps to 0.
- Masks: 4x4 per piece per rotation (28 constants).
  - I rot0 = mask row 1, cols 0-3. I rot1 = mask col 2, rows 0-3.
  - O (all rotations) = mask rows 1-2, cols 1-2.
- Cell coordinates: mask cell (i,j) maps to board (py+i, px+j). px is 5-bit signed, py is 6-bit signed.
- Collision when any set cell has col<0, col>11, row>19, or lands on an occupied board cell. Rows <0 are legal and not displayed.
- FSM:
  - SPAWN (1 cycle):
    - Load piece index, rot=0, px=SPAWN_X, py=SPAWN_Y.
    - If the spawned piece collides: game_over=1, go to OVER. Else go to PLAY.
  - PLAY:
    - At most one command per cycle. Priority: tick > btn_rot > btn_left > btn_right; lower-priority simultaneous pulses are dropped.
    - A candidate move is applied only if collision-free; otherwise it is ignored and the piece stays put.
    - A tick whose candidate collides goes to LOCK.
  - LOCK (1 cycle):
    - OR the piece cells into the board.
    - If any piece cell has row<0: game_over=1, go to OVER. Else go to CLEAR with scan row=19.
  - CLEAR (1 cycle per step):
    - If the scan row is full: rows 1..row take the contents of rows 0..row-1, row 0 is cleared, lines_cleared+1, and the same row is rescanned.
    - Else: row-1.
    - After row 0 is scanned, go to SPAWN.
  - OVER: terminal. Board and board_data are frozen; all inputs ignored.
- board_data timing:
  - Registered each cycle as board OR active-piece cells.
  - In SPAWN/PLAY it reflects the piece state of the previous cycle (1-cycle latency).
  - In LOCK/CLEAR/OVER it shows the board only.
- Mid-operation reset (rst=0 in any state) takes priority over everything.

Optional Feature:
PIECE_LFSR_EN
- Defined: the next piece comes from a 16-bit Fibonacci LFSR (taps 16,14,13,11). It advances every cycle; index = lfsr[2:0], with 7 mapped to 0. piece_sel is ignored.
- Undefined: next piece = piece_sel sampled in SPAWN, which gives deterministic benches. The port exists in both builds.

Test Plan:
1. Release reset with piece_sel=0, wait 2 cycles -> board_data[227:216]=12'b000011110000, all other bits 0, busy=0.
2. I piece, 10 btn_left pulses -> stops at px=0: row 1 = 12'b111100000000; the extra pulses change nothing.
3. I piece, 1 btn_rot -> cols 6 of rows 0-3 set: bits 233, 221, 209, 197 = 1.
4. piece_sel=0, tick + btn_left in the same cycle -> only the down move is applied, row 2 = 12'b000011110000. Then 25 ticks -> piece locks at row 19 = 12'b000011110000 and a new piece spawns.
5. piece_sel=1 (O), six pieces placed at px=-1,1,3,5,7,9 with ticks until lock -> rows 18-19 fill and clear: lines_cleared=2, board_data=0 after CLEAR.
6. piece_sel=1, repeated ticks with no moves -> the 10th spawn collides: game_over=1; later pulses leave board_data unchanged; rst=0 clears all state.

Source files
------------

// File: rtl/tetris_board_engine.sv
// tetris_board_engine: 20x12 Tetris playfield engine.
// Holds the locked board and one active tetromino. It applies gravity, move and
// rotate commands with collision checks, locks pieces, clears full rows and
// spawns the next piece. board_data is the registered display word: row 0 is
// the top row and the MSB of each 12-bit row is the leftmost column.
// Optional build macro PIECE_LFSR_EN: the next piece comes from a free-running
// 16-bit LFSR instead of the piece_sel input.
module tetris_board_engine #(
    parameter logic signed [4:0] SPAWN_X   = 5'sd4,
    parameter logic signed [5:0] SPAWN_Y   = 6'sd0,
    parameter logic [15:0]       LFSR_SEED = 16'hACE1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         btn_left,
    input  logic         btn_right,
    input  logic         btn_rot,
    input  logic         tick,
    input  logic [2:0]   piece_sel,
    output logic [239:0] board_data,
    output logic [15:0]  lines_cleared,
    output logic         game_over,
    output logic         busy
);

    localparam logic [2:0] ST_SPAWN = 3'd0;
    localparam logic [2:0] ST_PLAY  = 3'd1;
    localparam logic [2:0] ST_LOCK  = 3'd2;
    localparam logic [2:0] ST_CLEAR = 3'd3;
    localparam logic [2:0] ST_OVER  = 3'd4;

    logic [2:0]         state_q, state_d;
    logic [239:0]       board_q, board_d;
    logic [239:0]       board_data_q, board_data_d;
    logic [2:0]         piece_q, piece_d;
    logic [1:0]         rot_q, rot_d;
    logic signed [4:0]  px_q, px_d;
    logic signed [5:0]  py_q, py_d;
    logic [4:0]         row_q, row_d;
    logic [15:0]        lines_q, lines_d;
    logic               over_q, over_d;

    logic [2:0]         piece_raw;
    logic [2:0]         piece_next;

    // 4x4 mask, bit 15-(4*i+j) is mask cell (row i, col j)
    function automatic logic [15:0] piece_mask(input logic [2:0] p, input logic [1:0] r);
        logic [15:0] m;
        m = '0;
        case (p)
            3'd1: m = 16'h0660;
            3'd2: begin
                case (r)
                    2'd0:    m = 16'h4E00;
                    2'd1:    m = 16'h4640;
                    2'd2:    m = 16'h0E40;
                    default: m = 16'h4C40;
                endcase
            end
            3'd3: begin
                case (r)
                    2'd0:    m = 16'h6C00;
                    2'd1:    m = 16'h4620;
                    2'd2:    m = 16'h06C0;
                    default: m = 16'h8C40;
                endcase
            end
            3'd4: begin
                case (r)
                    2'd0:    m = 16'hC600;
                    2'd1:    m = 16'h2640;
                    2'd2:    m = 16'h0C60;
                    default: m = 16'h4C80;
                endcase
            end
            3'd5: begin
                case (r)
                    2'd0:    m = 16'h8E00;
                    2'd1:    m = 16'h6440;
                    2'd2:    m = 16'h0E20;
                    default: m = 16'h44C0;
                endcase
            end
            3'd6: begin
                case (r)
                    2'd0:    m = 16'h2E00;
                    2'd1:    m = 16'h4460;
                    2'd2:    m = 16'h0E80;
                    default: m = 16'hC440;
                endcase
            end
            default: begin
                case (r)
                    2'd0:    m = 16'h0F00;
                    2'd1:    m = 16'h2222;
                    2'd2:    m = 16'h00F0;
                    default: m = 16'h4444;
                endcase
            end
        endcase
        return m;
    endfunction

    // Visible cells of a piece placed at (y,x); cells above row 0 are dropped
    function automatic logic [239:0] piece_cells(input logic [2:0] p, input logic [1:0] r,
                                                 input logic signed [4:0] x,
                                                 input logic signed [5:0] y);
        logic [15:0]  m;
        logic [239:0] c;
        logic [3:0]   mi;
        logic [7:0]   idx;
        int           row;
        int           col;
        m = piece_mask(p, r);
        c = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            for (int unsigned j = 0; j < 4; j++) begin
                mi  = 4'(15 - 4 * i - j);
                row = int'(y) + int'(i);
                col = int'(x) + int'(j);
                idx = 8'(239 - 12 * row - col);
                if (m[mi] && row >= 0 && row <= 19 && col >= 0 && col <= 11)
                    c[idx] = 1'b1;
            end
        end
        return c;
    endfunction

    // Walls and floor block; rows above the top are open space
    function automatic logic collides(input logic [2:0] p, input logic [1:0] r,
                                      input logic signed [4:0] x,
                                      input logic signed [5:0] y,
                                      input logic [239:0] b);
        logic [15:0] m;
        logic [3:0]  mi;
        logic [7:0]  idx;
        logic        hit;
        int          row;
        int          col;
        m   = piece_mask(p, r);
        hit = 1'b0;
        for (int unsigned i = 0; i < 4; i++) begin
            for (int unsigned j = 0; j < 4; j++) begin
                mi  = 4'(15 - 4 * i - j);
                row = int'(y) + int'(i);
                col = int'(x) + int'(j);
                idx = 8'(239 - 12 * row - col);
                if (m[mi]) begin
                    if (col < 0 || col > 11 || row > 19)
                        hit = 1'b1;
                    else if (row >= 0 && b[idx])
                        hit = 1'b1;
                end
            end
        end
        return hit;
    endfunction

    // True when any set cell of the piece lies above row 0
    function automatic logic above_top(input logic [2:0] p, input logic [1:0] r,
                                       input logic signed [5:0] y);
        logic [15:0] m;
        logic [3:0]  mi;
        logic        hit;
        m   = piece_mask(p, r);
        hit = 1'b0;
        for (int unsigned i = 0; i < 4; i++) begin
            for (int unsigned j = 0; j < 4; j++) begin
                mi = 4'(15 - 4 * i - j);
                if (m[mi] && (int'(y) + int'(i)) < 0)
                    hit = 1'b1;
            end
        end
        return hit;
    endfunction

`ifdef PIECE_LFSR_EN
    logic [15:0] lfsr_q, lfsr_d;
    logic        unused_sel;

    assign lfsr_d     = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    assign piece_raw  = lfsr_q[2:0];
    assign unused_sel = ^piece_sel;

    // Free-running piece generator, advances every cycle
    always_ff @(posedge clk) begin
        if (!rst) lfsr_q <= LFSR_SEED;
        else      lfsr_q <= lfsr_d;
    end
`else
    logic unused_seed;

    assign piece_raw   = piece_sel;
    assign unused_seed = ^LFSR_SEED;
`endif

    assign piece_next = (piece_raw == 3'd7) ? 3'd0 : piece_raw;

    // Row-clear datapath: the board is a flat word, so the scanned row is found
    // by shifting it down to bit 0 and the collapse is a 12-bit right shift
    // confined to the rows at and above the scan row.
    logic [8:0]   row_sh;
    logic [8:0]   top_sh;
    logic [239:0] row_win;
    logic [239:0] top_mask;
    logic [239:0] board_clr;
    logic         row_full;

    // Full-row detect and collapse for the current scan row
    always_comb begin
        row_sh    = 9'(5'd19 - row_q) * 9'd12;
        top_sh    = (9'(row_q) + 9'd1) * 9'd12;
        row_win   = board_q >> row_sh;
        row_full  = &row_win[11:0];
        top_mask  = ~({240{1'b1}} >> top_sh);
        board_clr = ((board_q >> 12) & top_mask) | (board_q & ~top_mask);
    end

    // Game FSM: spawn, command handling, lock and row clearing
    always_comb begin
        state_d = state_q;
        board_d = board_q;
        piece_d = piece_q;
        rot_d   = rot_q;
        px_d    = px_q;
        py_d    = py_q;
        row_d   = row_q;
        lines_d = lines_q;
        over_d  = over_q;
        case (state_q)
            ST_SPAWN: begin
                piece_d = piece_next;
                rot_d   = 2'd0;
                px_d    = SPAWN_X;
                py_d    = SPAWN_Y;
                if (collides(piece_next, 2'd0, SPAWN_X, SPAWN_Y, board_q)) begin
                    over_d  = 1'b1;
                    state_d = ST_OVER;
                end else begin
                    state_d = ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (tick) begin
                    if (collides(piece_q, rot_q, px_q, py_q + 6'sd1, board_q))
                        state_d = ST_LOCK;
                    else
                        py_d = py_q + 6'sd1;
                end else if (btn_rot) begin
                    if (!collides(piece_q, rot_q + 2'd1, px_q, py_q, board_q))
                        rot_d = rot_q + 2'd1;
                end else if (btn_left) begin
                    if (!collides(piece_q, rot_q, px_q - 5'sd1, py_q, board_q))
                        px_d = px_q - 5'sd1;
                end else if (btn_right) begin
                    if (!collides(piece_q, rot_q, px_q + 5'sd1, py_q, board_q))
                        px_d = px_q + 5'sd1;
                end
            end
            ST_LOCK: begin
                board_d = board_q | piece_cells(piece_q, rot_q, px_q, py_q);
                if (above_top(piece_q, rot_q, py_q)) begin
                    over_d  = 1'b1;
                    state_d = ST_OVER;
                end else begin
                    row_d   = 5'd19;
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                if (row_full) begin
                    board_d = board_clr;
                    lines_d = lines_q + 16'd1;
                end else if (row_q == 5'd0) begin
                    state_d = ST_SPAWN;
                end else begin
                    row_d = row_q - 5'd1;
                end
            end
            ST_OVER: begin
            end
            default: state_d = ST_SPAWN;
        endcase
    end

    // Display word: the piece is overlaid only while it is live in PLAY, so a
    // just-locked piece never ghosts over rows that CLEAR has since shifted.
    always_comb begin
        if (state_q == ST_PLAY)
            board_data_d = board_q | piece_cells(piece_q, rot_q, px_q, py_q);
        else
            board_data_d = board_q;
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_SPAWN;
            board_q      <= '0;
            board_data_q <= '0;
            piece_q      <= '0;
            rot_q        <= '0;
            px_q         <= SPAWN_X;
            py_q         <= SPAWN_Y;
            row_q        <= 5'd19;
            lines_q      <= '0;
            over_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            board_q      <= board_d;
            board_data_q <= board_data_d;
            piece_q      <= piece_d;
            rot_q        <= rot_d;
            px_q         <= px_d;
            py_q         <= py_d;
            row_q        <= row_d;
            lines_q      <= lines_d;
            over_q       <= over_d;
        end
    end

    assign board_data    = board_data_q;
    assign lines_cleared = lines_q;
    assign game_over     = over_q;
    assign busy          = (state_q == ST_SPAWN) || (state_q == ST_LOCK) || (state_q == ST_CLEAR);

endmodule
